// File: rtl/sim_mem_responder_if.sv
// Per-lane A/D memory request bus between a request generator (master) and a responder (slave).
// Lane g of each packed vector occupies [W*g +: W].
interface sim_mem_responder_if #(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned LOGSIZE_WIDTH = 4
);
  logic [NUM_LANES-1:0]               a_valid;
  logic [NUM_LANES-1:0]               a_ready;
  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address;
  logic [NUM_LANES-1:0]               a_is_store;
  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size;
  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data;
  logic [NUM_LANES-1:0]               d_valid;
  logic [NUM_LANES-1:0]               d_ready;
  logic [NUM_LANES-1:0]               d_is_store;
  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size;
  logic [DATA_WIDTH*NUM_LANES-1:0]    d_data;

  modport master (
    output a_valid, a_address, a_is_store, a_size, a_data, d_ready,
    input  a_ready, d_valid, d_is_store, d_size, d_data
  );

  modport slave (
    input  a_valid, a_address, a_is_store, a_size, a_data, d_ready,
    output a_ready, d_valid, d_is_store, d_size, d_data
  );
endinterface

// File: rtl/sim_mem_responder.sv
// Multi-lane memory responder: each lane performs loads/stores on a shared word RAM at accept
// time and returns one in-order response per request after a fixed minimum latency.
module sim_mem_responder #(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned LOGSIZE_WIDTH = 4,
  parameter int unsigned MEM_WORDS     = 1024,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned LATENCY       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  sim_mem_responder_if.slave   mem_if,
  output logic                 idle
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(MEM_WORDS);
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned OccW     = $clog2(DEPTH + 1);
  localparam int unsigned CntW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic logic [NumBytes-1:0] byte_en(input logic [LOGSIZE_WIDTH-1:0] size);
    logic [NumBytes-1:0] be;
    be = '0;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      if ((32'(size) >= OffW) || (b < (32'd1 << size))) be[b] = 1'b1;
    end
    return be;
  endfunction

  // Release is synchronised by one flop so the first accept lands on the second edge after
  // reset rises; assertion stays asynchronous.
  logic rst_sync_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  logic [NUM_LANES-1:0][OccW-1:0]             occ_q, occ_d;
  logic [NUM_LANES-1:0][PtrW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_LANES-1:0][DEPTH-1:0][CntW-1:0]  cnt_q, cnt_d;

  logic                     st_q   [NUM_LANES][DEPTH];
  logic [LOGSIZE_WIDTH-1:0] size_q [NUM_LANES][DEPTH];
  word_t                    data_q [NUM_LANES][DEPTH];
  word_t                    mem_q  [MEM_WORDS];

  logic [NUM_LANES-1:0]               accept, pop;
  logic [NUM_LANES-1:0][IdxW-1:0]     lane_idx;
  logic [NUM_LANES-1:0][NumBytes-1:0] lane_be;
  word_t                              load_word [NUM_LANES];

  // Only the word-index bits of the address matter.
  logic unused_addr;
  assign unused_addr = ^mem_if.a_address;

  always_comb begin
    accept            = '0;
    pop               = '0;
    idle              = 1'b1;
    mem_if.a_ready    = '0;
    mem_if.d_valid    = '0;
    mem_if.d_is_store = '0;
    mem_if.d_size     = '0;
    mem_if.d_data     = '0;
    for (int unsigned g = 0; g < NUM_LANES; g++) begin
      lane_idx[g] = mem_if.a_address[g*DATA_WIDTH + OffW +: IdxW];
      lane_be[g]  = byte_en(mem_if.a_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]);
      for (int unsigned b = 0; b < NumBytes; b++) begin
        load_word[g][b*8 +: 8] = lane_be[g][b] ? mem_q[lane_idx[g]][b*8 +: 8] : 8'h00;
      end

      mem_if.a_ready[g] = (occ_q[g] != OccW'(DEPTH));
      accept[g]         = rst_sync_q & mem_if.a_valid[g] & mem_if.a_ready[g];
      mem_if.d_valid[g] = (occ_q[g] != '0) && (cnt_q[g][rd_ptr_q[g]] == '0);
      pop[g]            = mem_if.d_valid[g] & mem_if.d_ready[g];
      if (occ_q[g] != '0) idle = 1'b0;

      // Payload is gated so an empty queue never shows stale entries.
      if (mem_if.d_valid[g]) begin
        mem_if.d_is_store[g]                               = st_q[g][rd_ptr_q[g]];
        mem_if.d_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]    = size_q[g][rd_ptr_q[g]];
        mem_if.d_data[g*DATA_WIDTH +: DATA_WIDTH]          = data_q[g][rd_ptr_q[g]];
      end

      occ_d[g]    = occ_q[g] + OccW'(accept[g]) - OccW'(pop[g]);
      wr_ptr_d[g] = wr_ptr_q[g] + PtrW'(accept[g]);
      rd_ptr_d[g] = rd_ptr_q[g] + PtrW'(pop[g]);
      for (int unsigned e = 0; e < DEPTH; e++) begin
        cnt_d[g][e] = (cnt_q[g][e] != '0) ? cnt_q[g][e] - CntW'(1) : '0;
        if (accept[g] && (wr_ptr_q[g] == PtrW'(e))) cnt_d[g][e] = CntInit;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Lanes are visited in ascending order so the highest lane wins each byte it writes.
  always_ff @(posedge clock or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      for (int unsigned w = 0; w < MEM_WORDS; w++) mem_q[w] <= '0;
    end else begin
      for (int unsigned g = 0; g < NUM_LANES; g++) begin
        if (accept[g] && mem_if.a_is_store[g]) begin
          for (int unsigned b = 0; b < NumBytes; b++) begin
            if (lane_be[g][b]) begin
              mem_q[lane_idx[g]][b*8 +: 8] <= mem_if.a_data[g*DATA_WIDTH + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Loads capture the pre-store RAM contents of the accepting edge.
  always_ff @(posedge clock) begin
    for (int unsigned g = 0; g < NUM_LANES; g++) begin
      if (accept[g]) begin
        st_q[g][wr_ptr_q[g]]   <= mem_if.a_is_store[g];
        size_q[g][wr_ptr_q[g]] <= mem_if.a_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
        data_q[g][wr_ptr_q[g]] <= mem_if.a_is_store[g] ? '0 : load_word[g];
      end
    end
  end

endmodule

// File: tb/tb_sim_mem_responder.sv
// Directed bench for sim_mem_responder: one LATENCY=4 instance for the functional tests and
// one LATENCY=1 instance for the throughput test.
module tb_sim_mem_responder;
  localparam int unsigned NL = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle4, idle1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [63:0] t2_dat [6];
  logic [3:0]  t2_sz  [6];

  sim_mem_responder_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW)) bif4 ();
  sim_mem_responder_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW)) bif1 ();

  sim_mem_responder #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW),
    .MEM_WORDS(64), .DEPTH(4), .LATENCY(4)
  ) u_dut4 (
    .clock (clk),
    .reset (rst_n),
    .mem_if(bif4),
    .idle  (idle4)
  );

  sim_mem_responder #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW),
    .MEM_WORDS(64), .DEPTH(4), .LATENCY(1)
  ) u_dut1 (
    .clock (clk),
    .reset (rst_n),
    .mem_if(bif1),
    .idle  (idle1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req4(input int lane, input logic st, input logic [63:0] addr,
                      input logic [3:0] sz, input logic [63:0] dat);
    bif4.a_valid[lane]              = 1'b1;
    bif4.a_is_store[lane]           = st;
    bif4.a_address[lane*DW +: DW]   = addr;
    bif4.a_size[lane*LW +: LW]      = sz;
    bif4.a_data[lane*DW +: DW]      = dat;
  endtask

  function automatic logic [63:0] dat4(input int lane);
    return bif4.d_data[lane*DW +: DW];
  endfunction

  function automatic logic [63:0] sz4(input int lane);
    return 64'(bif4.d_size[lane*LW +: LW]);
  endfunction

  // Waits (bounded) for a response on a lane of the LATENCY=4 instance and checks it.
  task automatic wait_resp(input int lane, input logic st, input logic [3:0] sz,
                           input logic [63:0] dat, input string tag);
    int n;
    n = 0;
    while (!bif4.d_valid[lane] && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, 64'(bif4.d_valid[lane]), 64'd1);
    check_eq({tag, "_st"}, 64'(bif4.d_is_store[lane]), 64'(st));
    check_eq({tag, "_size"}, sz4(lane), 64'(sz));
    check_eq({tag, "_data"}, dat4(lane), dat);
    step();
  endtask

  initial begin
    int i;
    int k;
    logic acc;
    t2_dat = '{64'h0D, 64'hF00D, 64'hCAFEF00D, 64'hDEADBEEF_CAFEF00D, 64'h0D, 64'hF00D};
    t2_sz  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    bif4.a_valid = '0; bif4.a_is_store = '0; bif4.a_address = '0; bif4.a_size = '0;
    bif4.a_data = '0; bif4.d_ready = '1;
    bif1.a_valid = '0; bif1.a_is_store = '0; bif1.a_address = '0; bif1.a_size = '0;
    bif1.a_data = '0; bif1.d_ready = '1;

    // Reset state
    repeat (3) step();
    check_eq("rst_a_ready", 64'(bif4.a_ready), 64'hF);
    check_eq("rst_d_valid", 64'(bif4.d_valid), 64'h0);
    check_eq("rst_idle", 64'(idle4), 64'h1);
    check_eq("rst_d_data", 64'(|bif4.d_data), 64'h0);
    check_eq("rst_d_meta", 64'({|bif4.d_size, |bif4.d_is_store}), 64'h0);
    rst_n = 1'b1;
    step();

    // Test 1: store then load, exact latency
    req4(0, 1'b1, 64'h40, 4'd3, 64'hDEADBEEF_CAFEF00D);
    step();
    req4(0, 1'b0, 64'h40, 4'd2, 64'h0);
    check_eq("t1_dv_e1", 64'(bif4.d_valid[0]), 64'h0);
    step();
    bif4.a_valid = '0;
    check_eq("t1_dv_e2", 64'(bif4.d_valid[0]), 64'h0);
    step();
    check_eq("t1_dv_e3", 64'(bif4.d_valid[0]), 64'h0);
    step();
    check_eq("t1_st_valid", 64'(bif4.d_valid[0]), 64'h1);
    check_eq("t1_st_is_store", 64'(bif4.d_is_store[0]), 64'h1);
    check_eq("t1_st_data", dat4(0), 64'h0);
    check_eq("t1_st_size", sz4(0), 64'd3);
    step();
    check_eq("t1_ld_valid", 64'(bif4.d_valid[0]), 64'h1);
    check_eq("t1_ld_is_store", 64'(bif4.d_is_store[0]), 64'h0);
    check_eq("t1_ld_data", dat4(0), 64'h00000000_CAFEF00D);
    check_eq("t1_ld_size", sz4(0), 64'd2);
    step();
    check_eq("t1_dv_after", 64'(bif4.d_valid[0]), 64'h0);
    check_eq("t1_idle", 64'(idle4), 64'h1);

    // Test 2: backpressure on lane 1, 6 loads into a depth-4 queue
    bif4.d_ready[1] = 1'b0;
    i = 0;
    for (int c = 0; c < 8; c++) begin
      if (i < 6) req4(1, 1'b0, 64'h40, t2_sz[i], 64'h0);
      acc = (i < 6) && bif4.a_ready[1];
      step();
      if (acc) i++;
    end
    check_eq("t2_accepted", 64'(i), 64'd4);
    check_eq("t2_a_ready_low", 64'(bif4.a_ready[1]), 64'h0);
    check_eq("t2_idle_low", 64'(idle4), 64'h0);
    bif4.d_ready[1] = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      if (i < 6) req4(1, 1'b0, 64'h40, t2_sz[i], 64'h0);
      else bif4.a_valid[1] = 1'b0;
      if (bif4.d_valid[1]) begin
        check_eq("t2_resp_data", dat4(1), t2_dat[k]);
        check_eq("t2_resp_size", sz4(1), 64'(t2_sz[k]));
        k++;
      end
      acc = (i < 6) && bif4.a_ready[1];
      step();
      if (acc) i++;
    end
    bif4.a_valid = '0;
    check_eq("t2_resp_count", 64'(k), 64'd6);
    step();
    check_eq("t2_idle_end", 64'(idle4), 64'h1);

    // Test 3: four lanes store the same word, highest lane wins
    req4(0, 1'b1, 64'h80, 4'd3, 64'h11111111_11111111);
    req4(1, 1'b1, 64'h80, 4'd3, 64'h22222222_22222222);
    req4(2, 1'b1, 64'h80, 4'd3, 64'h33333333_33333333);
    req4(3, 1'b1, 64'h80, 4'd3, 64'h44444444_44444444);
    step();
    bif4.a_valid = '0;
    req4(0, 1'b0, 64'h80, 4'd3, 64'h0);
    step();
    bif4.a_valid = '0;
    wait_resp(0, 1'b1, 4'd3, 64'h0, "t3_st");
    wait_resp(0, 1'b0, 4'd3, 64'h44444444_44444444, "t3_ld");

    // Test 4: same-cycle load (lane 0) and store (lane 2) to one word
    req4(0, 1'b0, 64'h100, 4'd3, 64'h0);
    req4(2, 1'b1, 64'h100, 4'd3, 64'h01234567_89ABCDEF);
    step();
    bif4.a_valid = '0;
    wait_resp(0, 1'b0, 4'd3, 64'h0, "t4_old");
    req4(0, 1'b0, 64'h100, 4'd3, 64'h0);
    step();
    bif4.a_valid = '0;
    wait_resp(0, 1'b0, 4'd3, 64'h01234567_89ABCDEF, "t4_new");

    // Test 5: reset with responses pending on lane 2
    bif4.d_ready[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req4(2, 1'b0, 64'h40, 4'd3, 64'h0);
      step();
    end
    bif4.a_valid = '0;
    repeat (4) step();
    check_eq("t5_pending_valid", 64'(bif4.d_valid[2]), 64'h1);
    check_eq("t5_pending_idle", 64'(idle4), 64'h0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_d_valid", 64'(bif4.d_valid), 64'h0);
    check_eq("t5_rst_idle", 64'(idle4), 64'h1);
    check_eq("t5_rst_a_ready", 64'(bif4.a_ready), 64'hF);
    check_eq("t5_rst_d_data", 64'(|bif4.d_data), 64'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bif4.d_ready = '1;
    for (int c = 0; c < 6; c++) begin
      check_eq("t5_no_stale", 64'(bif4.d_valid), 64'h0);
      step();
    end
    req4(2, 1'b0, 64'h40, 4'd3, 64'h0);
    step();
    bif4.a_valid = '0;
    wait_resp(2, 1'b0, 4'd3, 64'h0, "t5_ld40");
    req4(0, 1'b0, 64'h100, 4'd3, 64'h0);
    step();
    bif4.a_valid = '0;
    wait_resp(0, 1'b0, 4'd3, 64'h0, "t5_ld100");

    // Test 6: LATENCY=1 streaming on lane 0 of the second instance
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        bif1.a_valid[0]          = 1'b1;
        bif1.a_is_store[0]       = 1'b1;
        bif1.a_address[0 +: DW]  = 64'(c * 8);
        bif1.a_size[0 +: LW]     = 4'd3;
        bif1.a_data[0 +: DW]     = 64'h100 + 64'(c);
        check_eq("t6_a_ready", 64'(bif1.a_ready[0]), 64'h1);
      end else begin
        bif1.a_valid = '0;
      end
      if (c > 0) check_eq("t6_d_valid", 64'(bif1.d_valid[0]), 64'h1);
      step();
    end
    check_eq("t6_drained", 64'(bif1.d_valid[0]), 64'h0);
    bif1.a_valid[0]         = 1'b1;
    bif1.a_is_store[0]      = 1'b0;
    bif1.a_address[0 +: DW] = 64'h28;
    bif1.a_size[0 +: LW]    = 4'd3;
    step();
    bif1.a_valid = '0;
    check_eq("t6_ld_valid", 64'(bif1.d_valid[0]), 64'h1);
    check_eq("t6_ld_data", bif1.d_data[0 +: DW], 64'h105);
    step();
    check_eq("t6_idle", 64'(idle1), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
